seq_memory: RTL and testbench

SEQ_MEMORY -- requirements
Module: seq_memory

---
 rtl/seq_memory.sv | 138 +++++++++++++
 tb/tb_seq_memory.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_memory.sv
// Colour-sequence memory for a "repeat the pattern" game.
// A free-running 16-bit LFSR supplies random colours. add_clr appends one colour
// to the sequence. A single pointer serves both playback (rewind/next_pulse) and
// checking the player's presses (check). Incoming strobes are priority-decoded
// into one action per cycle. That action is registered as the FSM state, and
// the compare-result pulses are decoded from the state that was registered.
module seq_memory #(
  parameter int          MAX_ROUND = 63,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rst_seed,
  input  logic       start_rng,
  input  logic       add_clr,
  input  logic       rewind,
  input  logic       next_pulse,
  input  logic       check,
  input  logic [1:0] press_color,
  output logic [5:0] current_round,
  output logic [1:0] play_color,
  output logic       last_pulse,
  output logic       full,
  output logic       match,
  output logic       mismatch,
  output logic       turn_done
);

  // The state records the action taken on the previous edge. The three
  // result states are what drive the one-cycle match/mismatch/turn_done pulses.
  typedef enum logic [3:0] {
    IDLE,
    RST_SEED,
    START_RNG,
    ADD_CLR,
    REWIND,
    IS_NEXT_PULSE,
    MATCH,
    MATCH_LAST,
    MISMATCH
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        running_q, running_d;
  logic [5:0]  round_q, round_d;
  logic [5:0]  ptr_q, ptr_d;

  // The memory is sized to the full 6-bit index space, so every pointer value
  // is in range. Only entries below current_round carry meaning.
  logic [1:0]  mem_q [0:63];
  logic        mem_we;

  logic [15:0] lfsr_step;
  logic [1:0]  mem_rd;
  logic        is_last;
  logic        is_full;
  logic        have_seq;

  assign lfsr_step = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign mem_rd    = mem_q[ptr_q];
  assign have_seq  = (round_q != 6'd0);
  assign is_last   = have_seq && (ptr_q == round_q - 6'd1);
  assign is_full   = (round_q == 6'(MAX_ROUND));

  assign current_round = round_q;
  assign play_color    = mem_rd;
  assign last_pulse    = is_last;
  assign full          = is_full;
  assign match         = (state_q == MATCH) || (state_q == MATCH_LAST);
  assign turn_done     = (state_q == MATCH_LAST);
  assign mismatch      = (state_q == MISMATCH);

  // Priority decode of the strobes and the datapath next-state. Only the
  // highest-priority strobe acts, so a check that loses priority yields no result.
  always_comb begin
    state_d   = IDLE;
    lfsr_d    = running_q ? lfsr_step : lfsr_q;
    running_d = running_q | start_rng;
    round_d   = round_q;
    ptr_d     = ptr_q;
    mem_we    = 1'b0;
    if (rst_seed) begin
      state_d   = RST_SEED;
      lfsr_d    = LFSR_SEED;
      running_d = 1'b0;
      round_d   = 6'd0;
      ptr_d     = 6'd0;
    end else if (add_clr) begin
      state_d = ADD_CLR;
      if (!is_full) begin
        mem_we  = 1'b1;
        round_d = round_q + 6'd1;
        ptr_d   = 6'd0;
      end
    end else if (rewind) begin
      state_d = REWIND;
      ptr_d   = 6'd0;
    end else if (check) begin
      if (have_seq && (press_color == mem_rd)) begin
        // A correct press on the last element ends the turn. The pointer
        // stays on that element rather than wrapping.
        state_d = is_last ? MATCH_LAST : MATCH;
        if (!is_last) ptr_d = ptr_q + 6'd1;
      end else begin
        state_d = MISMATCH;
      end
    end else if (next_pulse) begin
      state_d = IS_NEXT_PULSE;
      if (have_seq && !is_last) ptr_d = ptr_q + 6'd1;
    end else if (start_rng) begin
      state_d = START_RNG;
    end
  end

  // State and datapath registers. Reset returns to IDLE, which drops any result pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      lfsr_q    <= LFSR_SEED;
      running_q <= 1'b0;
      round_q   <= 6'd0;
      ptr_q     <= 6'd0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      running_q <= running_d;
      round_q   <= round_d;
      ptr_q     <= ptr_d;
    end
  end

  // Sequence storage. It is deliberately not reset: stale entries sit above current_round.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[round_q] <= lfsr_q[1:0];
  end

endmodule

// File: tb/tb_seq_memory.sv
// Bench for seq_memory. A behavioural model advances on each driven cycle and
// pushes the outputs it expects onto a queue. After the clock edge, those
// expected outputs are popped and compared against the DUT.
module tb_seq_memory;
  localparam int          MR   = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rst_seed = 1'b0, start_rng = 1'b0, add_clr = 1'b0;
  logic       rewind = 1'b0, next_pulse = 1'b0, check = 1'b0;
  logic [1:0] press_color = 2'd0;
  logic [5:0] current_round;
  logic [1:0] play_color;
  logic       last_pulse, full, match, mismatch, turn_done;

  always #5 clk = ~clk;

  seq_memory #(.MAX_ROUND(MR), .LFSR_SEED(SEED)) dut (
    .clk(clk), .reset(reset), .rst_seed(rst_seed), .start_rng(start_rng),
    .add_clr(add_clr), .rewind(rewind), .next_pulse(next_pulse), .check(check),
    .press_color(press_color), .current_round(current_round), .play_color(play_color),
    .last_pulse(last_pulse), .full(full), .match(match), .mismatch(mismatch),
    .turn_done(turn_done)
  );

  typedef struct packed {
    logic [5:0] rnd;
    logic       last, fl, mt, ms, td, pc_vld;
    logic [1:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // behavioural model state
  logic [15:0] m_lfsr;
  logic        m_run;
  int          m_round, m_ptr;
  logic [1:0]  m_mem [64];
  logic        m_mt, m_ms, m_td;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.rnd    = 6'(m_round);
    e.last   = (m_round != 0) && (m_ptr == m_round - 1);
    e.fl     = (m_round == MR);
    e.mt     = m_mt;
    e.ms     = m_ms;
    e.td     = m_td;
    e.pc_vld = (m_round != 0);
    e.pc     = m_mem[m_ptr];
    return e;
  endfunction

  task automatic model_reset();
    m_lfsr = SEED; m_run = 1'b0; m_round = 0; m_ptr = 0;
    m_mt = 1'b0; m_ms = 1'b0; m_td = 1'b0;
  endtask

  task automatic model_edge(input logic rs, sr, ac, rw, np, ck, input logic [1:0] pc);
    logic [15:0] old;
    old = m_lfsr;
    m_mt = 1'b0; m_ms = 1'b0; m_td = 1'b0;
    if (rs) begin
      model_reset();
    end else begin
      if (m_run) m_lfsr = {old[0] ^ old[2] ^ old[3] ^ old[5], old[15:1]};
      if (sr) m_run = 1'b1;
      if (ac) begin
        if (m_round < MR) begin
          m_mem[m_round] = old[1:0];
          m_round++;
          m_ptr = 0;
        end
      end else if (rw) begin
        m_ptr = 0;
      end else if (ck) begin
        if (m_round != 0 && pc == m_mem[m_ptr]) begin
          m_mt = 1'b1;
          if (m_ptr == m_round - 1) m_td = 1'b1;
          else m_ptr++;
        end else begin
          m_ms = 1'b1;
        end
      end else if (np) begin
        if (m_round != 0 && m_ptr != m_round - 1) m_ptr++;
      end
    end
  endtask

  task automatic compare_out(input exp_t e);
    chk("current_round", 32'(current_round), 32'(e.rnd));
    chk("last_pulse", 32'(last_pulse), 32'(e.last));
    chk("full", 32'(full), 32'(e.fl));
    chk("match", 32'(match), 32'(e.mt));
    chk("mismatch", 32'(mismatch), 32'(e.ms));
    chk("turn_done", 32'(turn_done), 32'(e.td));
    if (e.pc_vld) chk("play_color", 32'(play_color), 32'(e.pc));
  endtask

  task automatic step(input logic rs, sr, ac, rw, np, ck, input logic [1:0] pc);
    exp_t e;
    @(negedge clk);
    rst_seed = rs; start_rng = sr; add_clr = ac; rewind = rw;
    next_pulse = np; check = ck; press_color = pc;
    model_edge(rs, sr, ac, rw, np, ck, pc);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      compare_out(e);
    end
    rst_seed = 1'b0; start_rng = 1'b0; add_clr = 1'b0; rewind = 1'b0;
    next_pulse = 1'b0; check = 1'b0;
  endtask

  task automatic idle();                     step(0, 0, 0, 0, 0, 0, 2'd0); endtask
  task automatic reseed();                   step(1, 0, 0, 0, 0, 0, 2'd0); endtask
  task automatic start();                    step(0, 1, 0, 0, 0, 0, 2'd0); endtask
  task automatic add();                      step(0, 0, 1, 0, 0, 0, 2'd0); endtask
  task automatic rew();                      step(0, 0, 0, 1, 0, 0, 2'd0); endtask
  task automatic nxt();                      step(0, 0, 0, 0, 1, 0, 2'd0); endtask
  task automatic press(input logic [1:0] c); step(0, 0, 0, 0, 0, 1, c);    endtask

  // Reset is asserted mid-cycle, and the outputs are checked before any clock edge arrives.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    exp_q.delete();
    compare_out(model_out());
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();

    // First colour comes from the unstepped seed: 0xACE1[1:0] = 1.
    add();
    chk("seed_color", 32'(play_color), 32'd1);
    chk("seed_last", 32'(last_pulse), 32'd1);

    // The LFSR steps once, to 0x5670, before the colour is taken: the colour is 0.
    reseed();
    start();
    idle();
    add();
    chk("run_color", 32'(play_color), 32'd0);
    chk("run_round", 32'(current_round), 32'd1);

    // Three correct presses: turn_done comes only on the third, and the pointer holds at 2.
    add(); add(); rew();
    press(m_mem[m_ptr]);
    press(m_mem[m_ptr]);
    press(m_mem[m_ptr]);
    chk("turn_done_last", 32'(turn_done), 32'd1);
    chk("ptr_hold_last", 32'(last_pulse), 32'd1);
    press(m_mem[m_ptr]);                 // the player presses again at the end
    idle();

    // A wrong press gives mismatch, and the pointer stays at 0.
    reseed(); add(); add(); rew();
    press(~m_mem[m_ptr]);
    chk("wrong_mismatch", 32'(mismatch), 32'd1);
    chk("wrong_ptr0", 32'(last_pulse), 32'd0);
    idle();

    // Fill to MR: the fifth add is ignored. rst_seed then empties the sequence.
    reseed();
    for (int i = 0; i < 5; i++) add();
    chk("full_round", 32'(current_round), 32'd4);
    chk("full_flag", 32'(full), 32'd1);
    reseed();
    chk("reseed_full", 32'(full), 32'd0);

    // add_clr outranks a coincident check.
    add();
    step(0, 0, 1, 0, 0, 1, m_mem[0]);
    chk("add_vs_check", 32'(match | mismatch), 32'd0);
    // The rest of the priority order, next_pulse stopping at the end, and the empty sequence.
    step(0, 0, 0, 1, 0, 1, ~m_mem[m_ptr]);
    step(0, 0, 0, 0, 1, 1, m_mem[m_ptr]);
    nxt(); nxt(); nxt();
    reseed();
    press(2'd0);
    chk("empty_mismatch", 32'(mismatch), 32'd1);
    nxt();

    // A check, then reset in the following cycle: no result pulse appears after reset.
    add();
    press(m_mem[m_ptr]);
    do_reset();
    idle();
    idle();

    // Randomized mix of strobes. Presses are correct about half of the time.
    start();
    for (int i = 0; i < 60; i++) begin
      logic [1:0] c;
      c = ($urandom_range(0, 1) == 1) ? m_mem[m_ptr] : 2'($urandom_range(0, 3));
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1), c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
